mem_access_unit: RTL and testbench

MEM-stage load/store initiator that drives the single-port word-addressed data RAM (`A`, `WD`, `WE`, `RD`, combinational read, write on `posedge clk`). Accepts one load or store per request from the pipeline and performs byte/halfword/word accesses with sign or zero extension. Sub-word stores use a two-cycle read-modify-write because the RAM only writes whole words. Misaligned requests are detected, and a registered `done` pulse tells the pipeline when to release its MEM-stage stall.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_lane_unit.sv | 37 +++
 rtl/mem_access_unit.sv | 102 ++++++++++
 tb/tb_mem_access_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the MEM-stage load/store unit.
package mem_pkg;
    localparam int OP_STORE_BIT = 3;
    localparam int OP_UNS_BIT   = 2;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int ADDR_HI_DEF  = 14;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } mau_state_e;

    // Sub-word store captured for the write half of read-modify-write.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } rmw_req_t;
endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane logic: extracts/extends a load value and merges store data into a word.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word[{lane, 3'b000} +: 8];
    assign half_v = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_val = word;
        case (size)
            SZ_BYTE: load_val = {{24{byte_v[7] & ~uns}}, byte_v};
            SZ_HALF: load_val = {{16{half_v[15] & ~uns}}, half_v};
            default: load_val = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: if (lane[1]) merged[31:16] = wdata[15:0];
                     else         merged[15:0]  = wdata[15:0];
            default: merged = wdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a single-port word RAM; sub-word stores
// go through a two-cycle read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_HI = ADDR_HI_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err_align,
    output logic        err_range,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);
    mau_state_e  state;
    rmw_req_t    hold;
    logic [31:0] rmw_buf;
    logic [31:0] lane_word, lane_wdata, load_val, merged;
    logic [1:0]  size, lane_addr, lane_sz;
    logic        lane_uns;
    logic        in_rmw, accept, is_store, err_al, err_rg, err_any, sub_store;

    assign size      = op[1:0];
    assign in_rmw    = (state == ST_RMW_WR);
    assign req_ready = ~in_rmw;
    assign accept    = req_valid & ~in_rmw;
    assign is_store  = op[OP_STORE_BIT];

    assign err_al  = (size == 2'b11) ||
                     (size == SZ_HALF && addr[0]) ||
                     (size == SZ_WORD && addr[1:0] != 2'b00);
    assign err_rg  = |addr[31:ADDR_HI];
    assign err_any = err_al | err_rg;
    // Without an error, a non-word store is necessarily byte or half.
    assign sub_store = is_store && (size != SZ_WORD);

    // One lane unit serves both loads (IDLE, live RAM data) and the merge (RMW_WR).
    assign lane_word  = in_rmw ? rmw_buf          : mem_rd;
    assign lane_addr  = in_rmw ? hold.addr[1:0]   : addr[1:0];
    assign lane_sz    = in_rmw ? hold.size        : size;
    assign lane_uns   = in_rmw ? 1'b0             : op[OP_UNS_BIT];
    assign lane_wdata = in_rmw ? hold.wdata       : wdata;

    mem_lane_unit u_lane (
        .word     (lane_word),
        .lane     (lane_addr),
        .size     (lane_sz),
        .uns      (lane_uns),
        .wdata    (lane_wdata),
        .load_val (load_val),
        .merged   (merged)
    );

    assign mem_a  = in_rmw ? {hold.addr[31:2], 2'b00} : {addr[31:2], 2'b00};
    assign mem_wd = in_rmw ? merged : wdata;
    assign mem_we = in_rmw || (accept && is_store && !err_any && size == SZ_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold      <= '0;
            rmw_buf   <= '0;
            rdata     <= '0;
            done      <= 1'b0;
            err_align <= 1'b0;
            err_range <= 1'b0;
        end else begin
            done      <= 1'b0;
            err_align <= 1'b0;
            err_range <= 1'b0;
            if (in_rmw) begin
                state <= ST_IDLE;
                done  <= 1'b1;
            end else if (accept) begin
                if (err_any) begin
                    done      <= 1'b1;
                    err_align <= err_al;
                    err_range <= err_rg;
                    rdata     <= '0;
                end else if (!is_store) begin
                    done  <= 1'b1;
                    rdata <= load_val;
                end else if (!sub_store) begin
                    done <= 1'b1;
                end else begin
                    rmw_buf <= mem_rd;
                    hold    <= '{addr, wdata, size};
                    state   <= ST_RMW_WR;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-level memory model and a per-cycle checker.
module tb_mem_access_unit;
    localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010;
    localparam logic [3:0] LBU = 4'b0100, LHU = 4'b0101;
    localparam logic [3:0] SB = 4'b1000, SH = 4'b1001, SW = 4'b1010;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [3:0]  op = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;
    logic        done, err_align, err_range, mem_we;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_HI(14)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
        .err_align(err_align), .err_range(err_range), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    logic [31:0] ram     [0:4095];
    logic [31:0] ref_mem [0:4095];
    int wr_cnt = 0, exp_wr = 0;
    assign mem_rd = ram[mem_a[13:2]];
    always @(posedge clk) if (mem_we) begin
        ram[mem_a[13:2]] <= mem_wd;
        wr_cnt <= wr_cnt + 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected completions indexed by the cycle in which done must be visible.
    bit          exp_v   [0:4095];
    bit          exp_upd [0:4095];
    bit          exp_ea  [0:4095];
    bit          exp_er  [0:4095];
    logic [31:0] exp_rd  [0:4095];
    logic [31:0] cur_rd = '0;
    bit          chk_en = 0;
    int          done_cnt = 0;

    function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [1:0] a, input logic [3:0] o);
        logic [31:0] v;
        int sh;
        sh = int'(a) * 8;
        case (o[1:0])
            2'b00: begin v = (w >> sh) & 32'hFF;   if (!o[2] && v[7])  v = v | 32'hFFFF_FF00; end
            2'b01: begin v = (w >> sh) & 32'hFFFF; if (!o[2] && v[15]) v = v | 32'hFFFF_0000; end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] mdl_merge(input logic [31:0] w, input logic [1:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        sh   = int'(a) * 8;
        mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    always @(negedge clk) if (rst_n && chk_en) begin
        if (done) done_cnt++;
        if (exp_v[cyc]) begin
            if (exp_upd[cyc]) cur_rd = exp_rd[cyc];
            chk("done", 32'(done), 32'd1);
            chk("err_align", 32'(err_align), 32'(exp_ea[cyc]));
            chk("err_range", 32'(err_range), 32'(exp_er[cyc]));
        end else begin
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_err", {30'd0, err_align, err_range}, 32'd0);
        end
        chk("rdata", rdata, cur_rd);
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                         input bit abort, output int acc);
        int n;
        bit ea, er;
        logic [11:0] idx;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
        op = o; addr = a; wdata = w; req_valid = 1'b1;
        acc = cyc;
        idx = a[13:2];
        ea = (o[1:0] == 2'b11) || (o[1:0] == 2'b01 && a[0]) || (o[1:0] == 2'b10 && a[1:0] != 2'b00);
        er = (a >= 32'h4000);
        if (ea || er) begin
            exp_v[acc+1] = 1; exp_upd[acc+1] = 1; exp_rd[acc+1] = '0;
            exp_ea[acc+1] = ea; exp_er[acc+1] = er;
        end else if (!o[3]) begin
            exp_v[acc+1] = 1; exp_upd[acc+1] = 1;
            exp_rd[acc+1] = mdl_load(ref_mem[idx], a[1:0], o);
        end else if (o[1:0] == 2'b10) begin
            exp_v[acc+1] = 1;
            ref_mem[idx] = w; exp_wr++;
        end else begin
            exp_v[acc+2] = 1;
            if (!abort) begin
                ref_mem[idx] = mdl_merge(ref_mem[idx], a[1:0], o[1:0], w);
                exp_wr++;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_chk(input string nm, input logic [31:0] rd, input bit ea, input bit er);
        @(negedge clk); #1;
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_rdata"}, rdata, rd);
        chk({nm, "_errs"}, {30'd0, err_align, err_range}, {30'd0, ea, er});
    endtask

    initial begin
        int acc, c0, bad;
        for (int i = 0; i < 4096; i++) begin ram[i] = '0; ref_mem[i] = '0; end
        ram[0] = 32'h80FF_7F01; ref_mem[0] = 32'h80FF_7F01;
        ram[1] = 32'h1122_3344; ref_mem[1] = 32'h1122_3344;
        #12;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_flags", {29'd0, done, err_align, err_range}, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1; chk_en = 1;

        issue(LB, 0, 0, 0, acc);  wait_chk("lb0", 32'h0000_0001, 0, 0);
        issue(LB, 1, 0, 0, acc);  wait_chk("lb1", 32'h0000_007F, 0, 0);
        issue(LB, 2, 0, 0, acc);  wait_chk("lb2", 32'hFFFF_FFFF, 0, 0);
        issue(LB, 3, 0, 0, acc);  wait_chk("lb3", 32'hFFFF_FF80, 0, 0);
        issue(LBU, 3, 0, 0, acc); wait_chk("lbu3", 32'h0000_0080, 0, 0);
        issue(LH, 2, 0, 0, acc);  wait_chk("lh2", 32'hFFFF_80FF, 0, 0);
        issue(LHU, 2, 0, 0, acc); wait_chk("lhu2", 32'h0000_80FF, 0, 0);
        issue(LH, 1, 0, 0, acc);  wait_chk("lh1_align", 32'h0, 1, 0);

        issue(SB, 5, 32'h0000_00AB, 0, acc);
        chk("sb_ready_low", 32'(req_ready), 32'd0);
        chk("sb_we", 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        chk("sb_ready_back", 32'(req_ready), 32'd1);
        @(negedge clk); #1;
        chk("sb_done_t2", 32'(done), 32'd1);
        issue(LW, 4, 0, 0, acc);  wait_chk("lw4", 32'h1122_AB44, 0, 0);

        issue(SW, 8, 32'hDEAD_BEEF, 0, acc);
        issue(LW, 8, 0, 0, acc);  wait_chk("sw_lw8", 32'hDEAD_BEEF, 0, 0);

        c0 = done_cnt;
        for (int i = 0; i < 10; i++) issue(LW, 32'(i * 4), 0, 0, acc);
        @(negedge clk); #1;
        chk("ten_lw_done", 32'(done_cnt - c0), 32'd10);

        issue(LW, 32'h0000_4000, 0, 0, acc); wait_chk("lw_range", 32'h0, 0, 1);
        issue(SW, 6, 32'h1234_5678, 0, acc); wait_chk("sw_align", 32'h0, 1, 0);
        issue(SH, 32'h0000_4003, 32'h5555, 0, acc); wait_chk("sh_both", 32'h0, 1, 1);
        issue(SH, 14, 32'hCAFE_BABE, 0, acc);
        issue(LHU, 14, 0, 0, acc); wait_chk("sh_lhu14", 32'h0000_BABE, 0, 0);

        // Reset in the middle of RMW_WR must kill the write and the completion.
        issue(SH, 2, 32'h0000_9999, 1, acc);
        chk("abort_we_before", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        exp_v[acc+2] = 0;
        cur_rd = '0;
        #1;
        chk("abort_we_dropped", 32'(mem_we), 32'd0);
        #1 rst_n = 1'b1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        issue(LW, 0, 0, 0, acc);  wait_chk("abort_word0", 32'h80FF_7F01, 0, 0);

        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("mem_contents_bad_words", 32'(bad), 32'd0);
        chk("write_count", 32'(wr_cnt), 32'(exp_wr));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
